kernel_bd_dispatch: RTL
=======================

// Module: kernel_bd_dispatch
// PURPOSE
//  Consumes the 512-bit BD stream that the TX BD stage sends toward the kernel (bd2k_* AXIS), one BD per beat.
//  Decodes each BD into a DDR-write command for the kernel and buffers it in a CMD_DEPTH command FIFO.
//  Limits commands in flight to MAX_OST. Turns kernel completions into wr_ddr_rsp_en/wr_ddr_rsp_sn pulses back to the TX BD stage.
// PARAMETERS
//  CMD_DEPTH   16  command FIFO depth in entries; power of 2, >= 2
//  MAX_OST     8   max commands issued but not yet completed; 1..255
// PORTS
//  clk_sys          in   1    single system clock; all logic is on its rising edge
//  rst_n            in   1    reset; asynchronous assert, active-low
//  s_axis_tdata     in   512  BD beat: [63:0] addr, [95:64] len (bytes), [106:96] sn, others ignored
//  s_axis_tkeep     in   64   byte enables; a BD is valid only if [15:0] == 16'hFFFF
//  s_axis_tuser     in   60   ignored
//  s_axis_tlast     in   1    end of packet
//  s_axis_tvalid    in   1    beat valid
//  s_axis_tready    out  1    beat accepted when tvalid & tready
//  cmd_valid        out  1    command to kernel valid
//  cmd_ready        in   1    kernel accepts command
//  cmd_addr         out  64   DDR address
//  cmd_len          out  32   length in bytes, never 0
//  cmd_sn           out  11   BD sequence number
//  done_valid       in   1    one-cycle kernel completion strobe
//  done_sn          in   11   sn of the completed command
//  wr_ddr_rsp_en    out  1    one-cycle response pulse to the TX BD stage
//  wr_ddr_rsp_sn    out  11   sn carried with wr_ddr_rsp_en
//  ost_cnt          out  8    commands currently in flight
//  bd_drop_cnt      out  16   dropped BDs/beats; saturates at 16'hFFFF
//  sn_err           out  1    sticky flag: completion came back out of order
// BEHAVIOUR
//  Reset values (rst_n=0, asynchronous): s_axis_tready=0, cmd_valid=0, wr_ddr_rsp_en=0, wr_ddr_rsp_sn=0, ost_cnt=0, bd_drop_cnt=0, sn_err=0. FIFOs are emptied.
//  Input FSM has two states, ACCEPT and DROP; it enters ACCEPT on the first cycle after reset release.
//   ACCEPT: tready = !cmd_fifo_full. On each accepted beat:
//    - push {sn,len,addr} if tkeep[15:0]==16'hFFFF and len!=0; otherwise do not push and increment bd_drop_cnt.
//    - if tlast=0, go to DROP.
//   DROP: tready=1. Each accepted beat increments bd_drop_cnt. Return to ACCEPT on the beat with tlast=1.
//  Push latency: a beat accepted in cycle N appears at the FIFO head in cycle N+1. A push into a full FIFO is impossible because tready gates it.
//  Command issue:
//   - cmd_valid = !cmd_fifo_empty && (ost_cnt < MAX_OST).
//   - cmd_addr/cmd_len/cmd_sn come from the FIFO head and stay stable while cmd_valid=1 && cmd_ready=0.
//   - On cmd_valid & cmd_ready: pop the FIFO, push cmd_sn into the in-order sn queue (depth MAX_OST), ost_cnt += 1.
//  Completion:
//   - On done_valid, in the next cycle: wr_ddr_rsp_en=1 for exactly one cycle and wr_ddr_rsp_sn=done_sn.
//   - Pop the sn queue and decrement ost_cnt.
//   - If done_sn != sn queue head, set sn_err; it stays set until reset.
//  Issue and completion in the same cycle: ost_cnt is unchanged (+1 and -1 cancel); both queues update.
//  done_valid while ost_cnt==0 is a spurious completion:
//   - still pulse wr_ddr_rsp_en with done_sn and set sn_err;
//   - ost_cnt stays 0; no pop.
//  Counters and pointers: FIFO and queue pointers wrap modulo depth; the full flag uses an extra pointer bit. ost_cnt never exceeds MAX_OST. bd_drop_cnt saturates.
//  Reset asserted mid-packet or with commands in flight:
//   - all state and buffered commands are discarded; nothing is replayed;
//   - after release the FSM is in ACCEPT, so a partial packet still arriving is parsed as a new BD.
// TESTING
//  1 Reset behaviour: all outputs hold their reset values.
//  2 Basic flow:
//    - one BD (addr=64'h1000, len=32'h200, sn=11'd5, tkeep all ones, tlast=1) with cmd_ready=1
//      -> cmd_valid one cycle later with the same fields; ost_cnt=1;
//    - then done_valid with sn=5 -> wr_ddr_rsp_en pulse with sn=5 next cycle; ost_cnt=0; sn_err=0.
//  3 Back-pressure, cmd_ready held 0:
//    - send 20 BDs -> s_axis_tready drops after 16 are accepted;
//    - then cmd_ready=1 -> exactly 8 commands issue (MAX_OST); no more until done_valid arrives.
//  4 Drop cases:
//    - BD with len=0 -> no command, bd_drop_cnt=1;
//    - 3-beat packet -> first beat issues a command, the 2 tail beats raise bd_drop_cnt to 3;
//    - BD with tkeep[3:0]=0 -> bd_drop_cnt=4.
//  5 Completion errors:
//    - issue sn 1 then sn 2, complete sn 2 first -> rsp pulses with sn 2, sn_err=1, ost_cnt=1;
//    - a done_valid with ost_cnt=0 -> rsp pulse, ost_cnt stays 0.
//  6 Corner timing:
//    - issue and done in the same cycle -> ost_cnt unchanged;
//    - drop rst_n mid-packet -> outputs return to reset values immediately (asynchronous); no rsp pulses after release.

Source files
------------

// File: rtl/kernel_bd_dispatch.sv
// kernel_bd_dispatch: decodes BD beats into buffered DDR-write commands, caps commands in flight, and turns completions into response pulses.
module kernel_bd_dispatch #(
  parameter int CMD_DEPTH = 16,
  parameter int MAX_OST   = 8
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic [59:0]  s_axis_tuser,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [63:0]  cmd_addr,
  output logic [31:0]  cmd_len,
  output logic [10:0]  cmd_sn,
  input  logic         done_valid,
  input  logic [10:0]  done_sn,
  output logic         wr_ddr_rsp_en,
  output logic [10:0]  wr_ddr_rsp_sn,
  output logic [7:0]   ost_cnt,
  output logic [15:0]  bd_drop_cnt,
  output logic         sn_err
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int QW = MAX_OST > 1 ? $clog2(MAX_OST) : 1;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_DROP} state_t;
  state_t state_q, state_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [QW-1:0] qwp_q, qwp_d, qrp_q, qrp_d;
  logic [106:0] fifo_q [CMD_DEPTH];
  logic [10:0] sq_q [MAX_OST];
  logic [7:0] ost_q, ost_d;
  logic [15:0] drop_q, drop_d;
  logic err_q, err_d, rsp_en_q, rsp_en_d;
  logic [10:0] rsp_sn_q, rsp_sn_d;
  logic full, empty, beat, push, issue, qpop;
  logic unused_ok;
  assign unused_ok = ^{s_axis_tuser, s_axis_tdata[511:107], s_axis_tkeep[63:16]};
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = wp_q == rp_q;
  // ST_IDLE only exists while reset is held, keeping tready low until the first clock after release
  assign s_axis_tready = state_q == ST_DROP || (state_q == ST_ACCEPT && !full);
  assign beat = s_axis_tvalid && s_axis_tready;
  assign push = beat && state_q == ST_ACCEPT && s_axis_tkeep[15:0] == 16'hFFFF && s_axis_tdata[95:64] != '0;
  assign cmd_valid = !empty && ost_q < 8'(MAX_OST);
  assign issue = cmd_valid && cmd_ready;
  assign qpop = done_valid && ost_q != '0;
  assign {cmd_sn, cmd_len, cmd_addr} = fifo_q[rp_q[AW-1:0]];
  assign wr_ddr_rsp_en = rsp_en_q;
  assign wr_ddr_rsp_sn = rsp_sn_q;
  assign ost_cnt = ost_q;
  assign bd_drop_cnt = drop_q;
  assign sn_err = err_q;
  always_comb begin
    state_d = state_q == ST_IDLE ? ST_ACCEPT : beat ? (s_axis_tlast ? ST_ACCEPT : ST_DROP) : state_q;
    wp_d = push ? wp_q + (AW+1)'(1) : wp_q;
    rp_d = issue ? rp_q + (AW+1)'(1) : rp_q;
    qwp_d = issue ? (qwp_q == QW'(MAX_OST - 1) ? '0 : qwp_q + QW'(1)) : qwp_q;
    qrp_d = qpop ? (qrp_q == QW'(MAX_OST - 1) ? '0 : qrp_q + QW'(1)) : qrp_q;
    ost_d = ost_q + 8'(issue) - 8'(qpop);
    drop_d = beat && !push && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
    err_d = err_q || (done_valid && (ost_q == '0 || done_sn != sq_q[qrp_q]));
    rsp_en_d = done_valid;
    rsp_sn_d = done_valid ? done_sn : rsp_sn_q;
  end
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      qwp_q    <= '0;
      qrp_q    <= '0;
      ost_q    <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
      rsp_en_q <= 1'b0;
      rsp_sn_q <= '0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      qwp_q    <= qwp_d;
      qrp_q    <= qrp_d;
      ost_q    <= ost_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      rsp_en_q <= rsp_en_d;
      rsp_sn_q <= rsp_sn_d;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wp_q[AW-1:0]] <= s_axis_tdata[106:0];
    if (issue) sq_q[qwp_q] <= cmd_sn;
  end
endmodule
